// File: rtl/axi_ddr3_w_responder_if.sv
// rtl/axi_ddr3_w_responder_if.sv - AXI4 write channel bundle (AW/W/B) for the DDR3 write responder.
interface axi_ddr3_w_responder_if;
    logic [28:0] awaddr;
    logic [1:0]  awburst;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        awid;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bid;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awburst, awlen, awsize, awid, awvalid,
        output wdata, wlast, wvalid, bready,
        input  awready, wready, bresp, bid, bvalid
    );

    modport slave (
        input  awaddr, awburst, awlen, awsize, awid, awvalid,
        input  wdata, wlast, wvalid, bready,
        output awready, wready, bresp, bid, bvalid
    );
endinterface

// File: rtl/axi_ddr3_w_responder.sv
// rtl/axi_ddr3_w_responder.sv - AXI4 write-slave responder with word memory and side read port.
// Optional counters enabled by defining AXI_WR_STATS_EN.
module axi_ddr3_w_responder #(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_ddr3_w_responder_if.slave     s_axi,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [63:0]               mem_rd_data
`ifdef AXI_WR_STATS_EN
    ,
    output logic [31:0]               stat_bursts,
    output logic [31:0]               stat_beats,
    output logic [31:0]               stat_errors
`endif
);
    localparam int AW = MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
    state_t state, state_nxt;

    logic        awready_c, wready_c, bvalid_c;
    logic        aw_hs, w_hs, b_hs;

    // ptr carries one extra MSB so running off the top of memory is visible
    logic [AW:0] ptr;
    logic [7:0]  len;
    logic [8:0]  beat_cnt;
    logic        incr;
    logic        cfg_err;
    logic        addr_err;
    logic        ovf_err;
    logic [1:0]  bresp_q;
    logic        bid_q;

    logic        in_range, beat_ovf, wr_en;
    logic        dec_fin, slv_fin;
    logic        unused_bits;

    logic [63:0] mem [0:(1 << AW) - 1];

    assign unused_bits = ^s_axi.awaddr[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        awready_c = 1'b0;
        wready_c  = 1'b0;
        bvalid_c  = 1'b0;
        unique case (state)
            IDLE: begin
                awready_c = ~rst;
                if (s_axi.awvalid && !rst) state_nxt = DATA;
            end
            DATA: begin
                wready_c = 1'b1;
                if (s_axi.wvalid && s_axi.wlast) state_nxt = RESP;
            end
            RESP: begin
                bvalid_c = 1'b1;
                if (s_axi.bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_axi.awready = awready_c;
    assign s_axi.wready  = wready_c;
    assign s_axi.bvalid  = bvalid_c;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.bid     = bid_q;

    assign aw_hs = s_axi.awvalid & awready_c;
    assign w_hs  = s_axi.wvalid & wready_c;
    assign b_hs  = bvalid_c & s_axi.bready;

    // Beats past awlen+1 are consumed but never written
    assign in_range = (beat_cnt <= {1'b0, len});
    assign beat_ovf = w_hs & in_range & ptr[AW];
    assign wr_en    = w_hs & in_range & ~ptr[AW] & ~addr_err & ~cfg_err;

    assign dec_fin  = addr_err | ovf_err | beat_ovf;
    assign slv_fin  = cfg_err | (beat_cnt != {1'b0, len});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            len      <= '0;
            beat_cnt <= '0;
            incr     <= 1'b0;
            cfg_err  <= 1'b0;
            addr_err <= 1'b0;
            ovf_err  <= 1'b0;
            bresp_q  <= 2'b00;
            bid_q    <= 1'b0;
        end else if (aw_hs) begin
            ptr      <= {1'b0, s_axi.awaddr[AW+2:3]};
            len      <= s_axi.awlen;
            beat_cnt <= '0;
            incr     <= (s_axi.awburst == 2'b01);
            cfg_err  <= (s_axi.awsize != 3'd3) || s_axi.awburst[1];
            addr_err <= ((s_axi.awaddr >> (AW + 3)) != '0);
            ovf_err  <= 1'b0;
            bid_q    <= s_axi.awid;
        end else if (w_hs) begin
            if (beat_cnt != '1)
                beat_cnt <= beat_cnt + 1'b1;
            if (incr && !ptr[AW])
                ptr <= ptr + 1'b1;
            if (beat_ovf)
                ovf_err <= 1'b1;
            if (s_axi.wlast)
                bresp_q <= dec_fin ? 2'b11 : (slv_fin ? 2'b10 : 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr[AW-1:0]] <= s_axi.wdata;
    end

    // Separate registered read keeps read-first behaviour on a same-word write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_rd_data <= '0;
        else     mem_rd_data <= mem[mem_rd_addr];
    end

`ifdef AXI_WR_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_bursts <= '0;
            stat_beats  <= '0;
            stat_errors <= '0;
        end else begin
            if (b_hs && stat_bursts != '1)
                stat_bursts <= stat_bursts + 1'b1;
            if (w_hs && stat_beats != '1)
                stat_beats <= stat_beats + 1'b1;
            if (b_hs && bresp_q != 2'b00 && stat_errors != '1)
                stat_errors <= stat_errors + 1'b1;
        end
    end
`else
    logic unused_b_hs;
    assign unused_b_hs = b_hs;
`endif
endmodule

// File: tb/tb_axi_ddr3_w_responder.sv
// tb/tb_axi_ddr3_w_responder.sv - directed and randomized bench for axi_ddr3_w_responder.
module tb_axi_ddr3_w_responder;
    localparam int MAW   = 10;
    localparam int DEPTH = 1 << MAW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [MAW-1:0] mem_rd_addr = '0;
    logic [63:0]    mem_rd_data;
`ifdef AXI_WR_STATS_EN
    logic [31:0]    stat_bursts, stat_beats, stat_errors;
`endif

    axi_ddr3_w_responder_if s_axi ();

    axi_ddr3_w_responder #(.MEM_ADDR_WIDTH(MAW)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axi       (s_axi),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data)
`ifdef AXI_WR_STATS_EN
        ,
        .stat_bursts (stat_bursts),
        .stat_beats  (stat_beats),
        .stat_errors (stat_errors)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] ref_mem [0:DEPTH-1];
    bit          ref_vld [0:DEPTH-1];
    logic [63:0] bdata   [0:31];
    bit          probe_en = 1'b0;
    logic [63:0] probe_old;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what memory and response should look like after a burst of nbeats beats
    function automatic logic [1:0] model_burst(input logic [28:0] addr, input logic [1:0] bt,
                                               input int len, input logic [2:0] size, input int nbeats);
        bit dec, slv, cfg;
        int start, p;
        dec   = (addr >> (MAW + 3)) != 0;
        cfg   = (size != 3'd3) || (bt == 2'b10) || (bt == 2'b11);
        slv   = cfg || (nbeats != len + 1);
        start = int'(addr >> 3) % DEPTH;
        if (!dec) begin
            for (int k = 0; k < nbeats; k++) begin
                if (k > len) continue;
                p = (bt == 2'b01) ? start + k : start;
                if (p > DEPTH - 1) begin
                    dec = 1'b1;
                    continue;
                end
                if (!cfg) begin
                    ref_mem[p] = bdata[k];
                    ref_vld[p] = 1'b1;
                end
            end
        end
        return dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    endfunction

    task automatic burst(input logic [28:0] addr, input logic [1:0] bt, input logic [7:0] len,
                         input logic [2:0] size, input logic id, input int nbeats, input int hold,
                         input bit gaps);
        logic [1:0] exp;
        if (probe_en) probe_old = ref_mem[mem_rd_addr];
        exp = model_burst(addr, bt, int'(len), size, nbeats);
        s_axi.awaddr  = addr;
        s_axi.awburst = bt;
        s_axi.awlen   = len;
        s_axi.awsize  = size;
        s_axi.awid    = id;
        s_axi.awvalid = 1'b1;
        for (int i = 0; i < 20 && s_axi.awready !== 1'b1; i++) @(negedge clk);
        chk("aw_ready_wait", {63'd0, s_axi.awready}, 64'd1);
        @(negedge clk);
        s_axi.awvalid = 1'b0;
        chk("aw_ready_drop", {63'd0, s_axi.awready}, 64'd0);
        chk("w_ready_after_aw", {63'd0, s_axi.wready}, 64'd1);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && ($urandom % 3 == 0)) begin
                s_axi.wvalid = 1'b0;
                @(negedge clk);
            end
            s_axi.wvalid = 1'b1;
            s_axi.wdata  = bdata[k];
            s_axi.wlast  = (k == nbeats - 1);
            chk("w_ready_beat", {63'd0, s_axi.wready}, 64'd1);
            @(negedge clk);
        end
        s_axi.wvalid = 1'b0;
        s_axi.wlast  = 1'b0;
        chk("b_valid_after_last", {63'd0, s_axi.bvalid}, 64'd1);
        chk("w_ready_in_resp", {63'd0, s_axi.wready}, 64'd0);
        if (probe_en) chk("read_first", mem_rd_data, probe_old);
        for (int i = 0; i < hold; i++) begin
            chk("b_hold_valid", {63'd0, s_axi.bvalid}, 64'd1);
            chk("b_hold_resp", {62'd0, s_axi.bresp}, {62'd0, exp});
            chk("b_hold_id", {63'd0, s_axi.bid}, {63'd0, id});
            chk("b_hold_awready", {63'd0, s_axi.awready}, 64'd0);
            @(negedge clk);
        end
        s_axi.bready = 1'b1;
        chk("b_resp", {62'd0, s_axi.bresp}, {62'd0, exp});
        chk("b_id", {63'd0, s_axi.bid}, {63'd0, id});
        @(negedge clk);
        s_axi.bready = 1'b0;
        chk("b_valid_cleared", {63'd0, s_axi.bvalid}, 64'd0);
        chk("aw_ready_after_b", {63'd0, s_axi.awready}, 64'd1);
    endtask

    task automatic rd_word(input int idx);
        mem_rd_addr = MAW'(idx);
        @(negedge clk);
        if (ref_vld[idx]) chk($sformatf("mem[%0d]", idx), mem_rd_data, ref_mem[idx]);
    endtask

    task automatic fill(input int n);
        for (int k = 0; k < n; k++) bdata[k] = {$urandom, $urandom};
    endtask

    initial begin
        int word, r, nb, ln;
        logic [28:0] a;
        logic [1:0]  bt;
        logic [2:0]  sz;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            ref_vld[i] = 1'b0;
        end
        s_axi.awaddr = '0; s_axi.awburst = '0; s_axi.awlen = '0; s_axi.awsize = '0;
        s_axi.awid = 1'b0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wlast = 1'b0;
        s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_awready", {63'd0, s_axi.awready}, 64'd0);
        chk("rst_wready", {63'd0, s_axi.wready}, 64'd0);
        chk("rst_bvalid", {63'd0, s_axi.bvalid}, 64'd0);
        chk("rst_bresp", {62'd0, s_axi.bresp}, 64'd0);
        chk("rst_bid", {63'd0, s_axi.bid}, 64'd0);
        chk("rst_rd_data", mem_rd_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("awready_after_rst", {63'd0, s_axi.awready}, 64'd1);

        // INCR at 0x40, four beats
        bdata[0] = 64'h11; bdata[1] = 64'h22; bdata[2] = 64'h33; bdata[3] = 64'h44;
        burst(29'h40, 2'b01, 8'd3, 3'd3, 1'b1, 4, 0, 1'b0);
        for (int i = 8; i < 12; i++) rd_word(i);

        // FIXED at 0: last beat wins
        bdata[0] = 64'hA; bdata[1] = 64'hB; bdata[2] = 64'hC;
        burst(29'h0, 2'b00, 8'd2, 3'd3, 1'b0, 3, 0, 1'b1);
        rd_word(0);

        // Seed the top of memory, then out-of-range address must leave it alone
        fill(4);
        burst(29'(1020 * 8), 2'b01, 8'd3, 3'd3, 1'b0, 4, 0, 1'b1);
        fill(2);
        burst(29'h1FFF8, 2'b01, 8'd1, 3'd3, 1'b1, 2, 0, 1'b0);
        for (int i = 1020; i < 1024; i++) rd_word(i);

        // Run off the end of memory
        fill(2);
        burst(29'(1023 * 8), 2'b01, 8'd1, 3'd3, 1'b0, 2, 0, 1'b0);
        rd_word(1023); rd_word(0);

        // Early wlast, overrun, bad size, WRAP
        fill(2);
        burst(29'h100, 2'b01, 8'd3, 3'd3, 1'b1, 2, 0, 1'b1);
        fill(5);
        burst(29'h200, 2'b01, 8'd1, 3'd3, 1'b0, 5, 0, 1'b1);
        fill(2);
        burst(29'h40, 2'b01, 8'd1, 3'd2, 1'b1, 2, 0, 1'b0);
        fill(2);
        burst(29'h48, 2'b10, 8'd1, 3'd3, 1'b0, 2, 0, 1'b0);
        for (int i = 8; i < 12; i++) rd_word(i);
        for (int i = 32; i < 36; i++) rd_word(i);
        for (int i = 64; i < 68; i++) rd_word(i);

        // Back-pressured response plus read-first probe on word 9
        mem_rd_addr = MAW'(9);
        probe_en = 1'b1;
        fill(1);
        burst(29'h48, 2'b01, 8'd0, 3'd3, 1'b1, 1, 5, 1'b0);
        probe_en = 1'b0;
        chk("after_read_first", mem_rd_data, ref_mem[9]);

        // Randomized bursts
        for (int t = 0; t < 30; t++) begin
            word = int'($urandom_range(0, DEPTH - 1));
            a    = 29'(word << 3) | 29'($urandom % 8);
            if ($urandom % 10 == 0) a = a | (29'd1 << (13 + ($urandom % 16)));
            r  = int'($urandom % 8);
            bt = (r < 5) ? 2'b01 : (r < 7) ? 2'b00 : 2'(2 + ($urandom % 2));
            sz = ($urandom % 8 == 0) ? 3'($urandom % 3) : 3'd3;
            ln = int'($urandom % 8);
            r  = int'($urandom % 6);
            if (r == 0)                nb = ln + 1 + int'($urandom_range(1, 3));
            else if (r == 1 && ln > 0) nb = int'($urandom_range(1, ln));
            else                       nb = ln + 1;
            fill(nb);
            burst(a, bt, 8'(ln), sz, 1'($urandom), nb, int'($urandom % 4), 1'b1);
        end

        // Reset in the middle of a data phase
        fill(4);
        s_axi.awaddr = 29'h300; s_axi.awburst = 2'b01; s_axi.awlen = 8'd3;
        s_axi.awsize = 3'd3; s_axi.awid = 1'b1; s_axi.awvalid = 1'b1;
        chk("mid_aw_ready", {63'd0, s_axi.awready}, 64'd1);
        @(negedge clk);
        s_axi.awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_axi.wvalid = 1'b1; s_axi.wdata = bdata[k]; s_axi.wlast = 1'b0;
            @(negedge clk);
        end
        void'(model_burst(29'h300, 2'b01, 3, 3'd3, 2));
        rst = 1'b1;
        #1;
        chk("mid_rst_wready", {63'd0, s_axi.wready}, 64'd0);
        chk("mid_rst_awready", {63'd0, s_axi.awready}, 64'd0);
        chk("mid_rst_bvalid", {63'd0, s_axi.bvalid}, 64'd0);
        s_axi.wvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_bvalid", {63'd0, s_axi.bvalid}, 64'd0);
            chk("post_rst_awready", {63'd0, s_axi.awready}, 64'd1);
        end
        chk("post_rst_bresp", {62'd0, s_axi.bresp}, 64'd0);

        for (int i = 0; i < DEPTH; i++) if (ref_vld[i]) rd_word(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_ddr3_w_responder.md
Name: axi_ddr3_w_responder

Overview:
AXI4 write-slave responder: the other end of the DDR3 write master channel (29-bit address, 64-bit data, 1-bit ID, no WSTRB). Accepts one burst at a time and stores beats in an internal 64-bit word memory. Returns BRESP with the matching BID. A side read port lets testbenches and capture-readback logic check the stored data.

Parameters:
MEM_ADDR_WIDTH, 10, log2 of memory depth in 64-bit words (default 8 KiB); legal range 1..26

Ports:
clk  input  1  single clock for all logic
rst  input  1  asynchronous, active-high reset
s_axi_awaddr  input  29  burst byte address
s_axi_awburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_axi_awlen  input  8  beats minus one
s_axi_awsize  input  3  beat size; only 3 (8 bytes) is legal
s_axi_awid  input  1  transaction ID
s_axi_awvalid  input  1  address valid
s_axi_awready  output  1  address accept
s_axi_wdata  input  64  write data
s_axi_wlast  input  1  last beat flag from master
s_axi_wvalid  input  1  data valid
s_axi_wready  output  1  data accept
s_axi_bresp  output  2  write response
s_axi_bid  output  1  echoed awid
s_axi_bvalid  output  1  response valid
s_axi_bready  input  1  response accept
mem_rd_addr  input  MEM_ADDR_WIDTH  side-port word address
mem_rd_data  output  64  side-port data, 1-cycle latency

Behaviour:
- Reset values: awready=0, wready=0, bvalid=0, bresp=00, bid=0, mem_rd_data=0. Memory contents are not reset.
- FSM states: IDLE, DATA, RESP. awready=1 only in IDLE, starting the first cycle after rst deasserts.
- IDLE: when awvalid&&awready, capture addr/len/burst/size/id, decode errors, go to DATA. wready=1 from the next cycle.
- DATA: wready=1. Each wvalid&&wready beat is one beat.
  - Beat k (0-based) writes word ptr. ptr starts at awaddr[MEM_ADDR_WIDTH+2:3]; low 3 bits are ignored (aligned write).
  - INCR: ptr+1 per beat. FIXED: ptr constant.
- Exit DATA on the beat with wlast=1. Go to RESP; bvalid=1 on the next cycle.
- Early wlast (beat count < awlen+1): burst ends there, response SLVERR.
- Beats beyond awlen+1 without wlast: keep accepting and discard until wlast, response SLVERR.
- Error decode:
  - DECERR: awaddr[28:MEM_ADDR_WIDTH+3] != 0. Whole burst discarded.
  - DECERR: an INCR beat whose ptr would exceed 2^MEM_ADDR_WIDTH-1. That beat and later beats are dropped; earlier beats are written.
  - SLVERR: awsize != 3, WRAP, or reserved burst type. Data is consumed but not written.
  - Precedence: DECERR > SLVERR > OKAY.
- RESP: bvalid held with stable bresp/bid until bready. After the handshake, go to IDLE; awready=1 the following cycle. One outstanding transaction only.
- Side port: mem_rd_data = mem[mem_rd_addr] registered. Read-first: a same-cycle write to the same word returns old data.
- Reset asserted mid-burst: FSM returns to IDLE and all handshake outputs drop to 0 immediately. Partially written words remain; no response is issued.

Optional Feature:
AXI_WR_STATS_EN
- Defined: adds outputs stat_bursts[31:0], stat_beats[31:0] and stat_errors[31:0], all reset to 0.
  - stat_bursts increments on each B handshake.
  - stat_beats increments on each W handshake, discarded beats included.
  - stat_errors increments on each B handshake with bresp != 00.
  - All counters saturate at 0xFFFFFFFF.
- Undefined: these ports and counters do not exist.

Test Plan:
- Reset release, then INCR burst awaddr=0x40, awlen=3, awid=1, data 0x11..0x44 with wlast on beat 3 -> words 8..11 hold the data; bvalid the cycle after beat 3, bresp=00, bid=1.
- FIXED burst awaddr=0x0, awlen=2, data A,B,C -> word 0 = C, bresp=00.
- awaddr=0x1FFF8, awlen=1 with default MEM_ADDR_WIDTH -> both beats discarded, memory unchanged, bresp=11.
- INCR awaddr=(1023*8), awlen=1 -> word 1023 written, second beat dropped, bresp=11.
- wlast on beat 1 of awlen=3; separately, awsize=2 -> first case SLVERR after 2 beats; second case SLVERR with memory unchanged.
- bready held low for 5 cycles -> bvalid/bresp/bid stable and awready=0 throughout; awready=1 the cycle after the B handshake. Reset asserted mid-DATA -> wready=0 immediately and no bvalid.
